branch_flush_controller: RTL and testbench
==========================================

# branch_flush_controller

Sequencer for taken-branch redirection in the five-stage pipeline. It consumes the branch decision produced in the executing stage, and for a fixed number of cycles drives the PC-select mux and the IF/ID and ID/EX flush controls. It also arbitrates between the load-use stall request from the hazard unit and a branch redirect. When built with statistics, it additionally counts branches and flush cycles.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC and branch target.
- FLUSH_CYCLES, 2, total squash cycles per taken branch, including the redirect cycle; legal range 1–7.

Ports:
- Reset is synchronous and active-high.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- branchTakenInput  input  1  taken decision from executing-stage branch control.
- validExInput  input  1  EX stage holds a non-squashed instruction.
- branchTargetInput  input  PC_WIDTH  computed branch target.
- stallInput  input  1  load-use stall request from hazard unit.
- pcSelectOutput  output  1  1 = PC loads pcTargetOutput.
- pcTargetOutput  output  PC_WIDTH  captured branch target.
- pcWriteEnableOutput  output  1  PC register write enable.
- ifIdWriteEnableOutput  output  1  IF/ID register write enable.
- flushIfIdOutput  output  1  clear IF/ID to bubble.
- flushIdExOutput  output  1  clear ID/EX to bubble.
- busyOutput  output  1  high whenever state ≠ RUN.

## Operation
- States: RUN, REDIRECT, FLUSH. A 3-bit down-counter flushCount is used only in FLUSH.
- **RUN, accept:** if branchTakenInput && validExInput, capture branchTargetInput into the target register and go to REDIRECT at the next edge.
  - A taken branch with validExInput=0 is ignored.
- **RUN, outputs:**
  - pcSelect=0, both flushes from the stall path only.
  - stallInput=0: pcWriteEnable=1, ifIdWriteEnable=1, flushIdEx=0.
  - stallInput=1: pcWriteEnable=0, ifIdWriteEnable=0, flushIdEx=1 (bubble insert).
  - Stall outputs are combinational from stallInput; no latency.
- **Branch and stall in the same RUN cycle:** the branch wins the transition. The stall outputs still apply in that cycle, and the stalled instruction is squashed by the following flush.
- **REDIRECT (1 cycle):**
  - pcSelect=1, pcTarget=captured value, pcWriteEnable=1, ifIdWriteEnable=1, flushIfId=1, flushIdEx=1.
  - stallInput is ignored.
  - Next state: FLUSH with flushCount=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
- **FLUSH:**
  - pcSelect=0, pcWriteEnable=1, ifIdWriteEnable=1, flushIfId=1, flushIdEx=1.
  - flushCount decrements each cycle; at flushCount==1, return to RUN.
  - stallInput and branchTakenInput are ignored.
- pcTargetOutput holds the last captured target in every state; only REDIRECT makes it meaningful.
- busyOutput=1 in REDIRECT and FLUSH.

## Timing
- Branch resolves in cycle T → redirect in T+1 → busy for exactly FLUSH_CYCLES cycles (T+1 … T+FLUSH_CYCLES) → RUN at T+FLUSH_CYCLES+1. The earliest next branch is accepted in that cycle.
- All state, counter and target updates occur on the rising clock edge.
- While reset=1, all outputs are forced to 0 combinationally, including pcWriteEnable and ifIdWriteEnable.
- At the reset edge: state=RUN, flushCount=0, target=0.
- Reset asserted mid-REDIRECT or mid-FLUSH aborts the sequence; no pending redirect survives.
- The first cycle after reset deasserts is a normal RUN cycle.

## Configuration
- BRANCH_FLUSH_STATS_EN defined:
  - Adds output branchCountOutput[31:0], incremented on each RUN→REDIRECT transition.
  - Adds output flushCycleCountOutput[31:0], incremented every cycle with busyOutput=1.
  - Both counters clear on reset and wrap 0xFFFFFFFF→0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- FLUSH_CYCLES=2: reset 2 cycles, then branchTaken=1, valid=1, target=0x0040_0020 at T.
  - T+1: pcSelect=1, pcTarget=0x0040_0020, both flushes=1.
  - T+2: flushes=1, pcSelect=0.
  - T+3: busy=0.
- Branch with branchTaken=1, valid=0 → no state change; busy stays 0; all flushes 0.
- stallInput=1 for 3 RUN cycles → pcWriteEnable=0, ifIdWriteEnable=0, flushIdEx=1 in each of those cycles; flushIfId=0.
- Stall and taken branch in the same cycle:
  - That cycle: stall outputs.
  - Next cycle: REDIRECT.
  - A stall asserted during REDIRECT/FLUSH has no effect: pcWriteEnable=1.
- Reset asserted in cycle T+1 of a FLUSH_CYCLES=4 sequence → from T+2 state is RUN, busy=0, outputs are RUN values. A new branch at T+3 redirects at T+4.
- With BRANCH_FLUSH_STATS_EN and FLUSH_CYCLES=3: 5 taken branches → branchCountOutput=5, flushCycleCountOutput=15. Preload near wrap via 0xFFFFFFFF+1 → 0.

Source files
------------

// File: rtl/branch_flush_controller_if.sv
// Pipeline-side bundle of the branch flush controller: branch/stall requests in, PC and flush controls out.
interface branch_flush_controller_if #(
    parameter int PC_WIDTH = 32
);
  logic                branchTakenInput;
  logic                validExInput;
  logic [PC_WIDTH-1:0] branchTargetInput;
  logic                stallInput;
  logic                pcSelectOutput;
  logic [PC_WIDTH-1:0] pcTargetOutput;
  logic                pcWriteEnableOutput;
  logic                ifIdWriteEnableOutput;
  logic                flushIfIdOutput;
  logic                flushIdExOutput;
  logic                busyOutput;

  modport master (
    output branchTakenInput, validExInput, branchTargetInput, stallInput,
    input  pcSelectOutput, pcTargetOutput, pcWriteEnableOutput,
           ifIdWriteEnableOutput, flushIfIdOutput, flushIdExOutput, busyOutput
  );

  modport slave (
    input  branchTakenInput, validExInput, branchTargetInput, stallInput,
    output pcSelectOutput, pcTargetOutput, pcWriteEnableOutput,
           ifIdWriteEnableOutput, flushIfIdOutput, flushIdExOutput, busyOutput
  );
endinterface

// File: rtl/branch_flush_controller.sv
// Taken-branch redirect/flush sequencer with load-use stall arbitration.
// Optional branch/flush-cycle statistics counters enabled by BRANCH_FLUSH_STATS_EN.
module branch_flush_controller #(
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    branch_flush_controller_if.slave bus
`ifdef BRANCH_FLUSH_STATS_EN
    ,
    output logic [31:0] branchCountOutput,
    output logic [31:0] flushCycleCountOutput
`endif
);

  typedef enum logic [1:0] {RUN, REDIRECT, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [2:0]          flush_count_reg, flush_count_next;
  logic [PC_WIDTH-1:0] target_reg, target_next;

  logic pc_select;
  logic pc_write_enable;
  logic if_id_write_enable;
  logic flush_if_id;
  logic flush_id_ex;
  logic busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= RUN;
      flush_count_reg <= 3'd0;
      target_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      flush_count_reg <= flush_count_next;
      target_reg      <= target_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    flush_count_next   = flush_count_reg;
    target_next        = target_reg;
    pc_select          = 1'b0;
    pc_write_enable    = 1'b0;
    if_id_write_enable = 1'b0;
    flush_if_id        = 1'b0;
    flush_id_ex        = 1'b0;
    busy               = 1'b0;
    case (state_reg)
      RUN: begin
        // Stall controls still apply when a branch is accepted in the same
        // cycle; the stalled instruction is squashed by the ensuing flush.
        pc_write_enable    = ~bus.stallInput;
        if_id_write_enable = ~bus.stallInput;
        flush_id_ex        = bus.stallInput;
        if (bus.branchTakenInput && bus.validExInput) begin
          state_next  = REDIRECT;
          target_next = bus.branchTargetInput;
        end
      end
      REDIRECT: begin
        pc_select          = 1'b1;
        pc_write_enable    = 1'b1;
        if_id_write_enable = 1'b1;
        flush_if_id        = 1'b1;
        flush_id_ex        = 1'b1;
        busy               = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_next       = FLUSH;
          flush_count_next = FLUSH_LOAD;
        end else begin
          state_next = RUN;
        end
      end
      FLUSH: begin
        pc_write_enable    = 1'b1;
        if_id_write_enable = 1'b1;
        flush_if_id        = 1'b1;
        flush_id_ex        = 1'b1;
        busy               = 1'b1;
        flush_count_next   = flush_count_reg - 3'd1;
        if (flush_count_reg == 3'd1) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next       = RUN;
        flush_count_next = 3'd0;
      end
    endcase
  end

  // Reset masks every output, including the write enables, with no latency.
  assign bus.pcSelectOutput        = ~reset & pc_select;
  assign bus.pcTargetOutput        = reset ? '0 : target_reg;
  assign bus.pcWriteEnableOutput   = ~reset & pc_write_enable;
  assign bus.ifIdWriteEnableOutput = ~reset & if_id_write_enable;
  assign bus.flushIfIdOutput       = ~reset & flush_if_id;
  assign bus.flushIdExOutput       = ~reset & flush_id_ex;
  assign bus.busyOutput            = ~reset & busy;

`ifdef BRANCH_FLUSH_STATS_EN
  logic [31:0] branch_count_reg;
  logic [31:0] flush_cycle_count_reg;
  logic        branch_start;

  assign branch_start = (state_reg == RUN) && (state_next == REDIRECT);

  always_ff @(posedge clock) begin
    if (reset) begin
      branch_count_reg      <= 32'd0;
      flush_cycle_count_reg <= 32'd0;
    end else begin
      if (branch_start) begin
        branch_count_reg <= branch_count_reg + 32'd1;
      end
      if (busy) begin
        flush_cycle_count_reg <= flush_cycle_count_reg + 32'd1;
      end
    end
  end

  assign branchCountOutput     = reset ? 32'd0 : branch_count_reg;
  assign flushCycleCountOutput = reset ? 32'd0 : flush_cycle_count_reg;
`endif

endmodule

// File: tb/tb_branch_flush_controller.sv
// Directed bench: FLUSH_CYCLES=2 instance (a) and FLUSH_CYCLES=4 instance (b).
module tb_branch_flush_controller;

  localparam int PC_WIDTH = 32;

  // Output vector order: {pcSelect, pcWriteEnable, ifIdWriteEnable, flushIfId, flushIdEx, busy}
  localparam logic [5:0] OUT_ZERO  = 6'b000000;
  localparam logic [5:0] OUT_RUN   = 6'b011000;
  localparam logic [5:0] OUT_STALL = 6'b000010;
  localparam logic [5:0] OUT_REDIR = 6'b111111;
  localparam logic [5:0] OUT_FLUSH = 6'b011111;

  logic                clock = 1'b0;
  logic                reset_a, reset_b;
  logic                taken, valid, stall;
  logic [PC_WIDTH-1:0] target;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  branch_flush_controller_if #(.PC_WIDTH(PC_WIDTH)) if_a ();
  branch_flush_controller_if #(.PC_WIDTH(PC_WIDTH)) if_b ();

  assign if_a.branchTakenInput  = taken;
  assign if_a.validExInput      = valid;
  assign if_a.branchTargetInput = target;
  assign if_a.stallInput        = stall;
  assign if_b.branchTakenInput  = taken;
  assign if_b.validExInput      = valid;
  assign if_b.branchTargetInput = target;
  assign if_b.stallInput        = stall;

`ifdef BRANCH_FLUSH_STATS_EN
  logic [31:0] branch_count_a, flush_cycle_count_a;
  logic [31:0] branch_count_b, flush_cycle_count_b;
`endif

  branch_flush_controller #(.PC_WIDTH(PC_WIDTH), .FLUSH_CYCLES(2)) dut_a (
      .clock(clock),
      .reset(reset_a),
      .bus  (if_a.slave)
`ifdef BRANCH_FLUSH_STATS_EN
      ,
      .branchCountOutput    (branch_count_a),
      .flushCycleCountOutput(flush_cycle_count_a)
`endif
  );

  branch_flush_controller #(.PC_WIDTH(PC_WIDTH), .FLUSH_CYCLES(4)) dut_b (
      .clock(clock),
      .reset(reset_b),
      .bus  (if_b.slave)
`ifdef BRANCH_FLUSH_STATS_EN
      ,
      .branchCountOutput    (branch_count_b),
      .flushCycleCountOutput(flush_cycle_count_b)
`endif
  );

  wire [5:0] outs_a = {if_a.pcSelectOutput, if_a.pcWriteEnableOutput, if_a.ifIdWriteEnableOutput,
                       if_a.flushIfIdOutput, if_a.flushIdExOutput, if_a.busyOutput};
  wire [5:0] outs_b = {if_b.pcSelectOutput, if_b.pcWriteEnableOutput, if_b.ifIdWriteEnableOutput,
                       if_b.flushIfIdOutput, if_b.flushIdExOutput, if_b.busyOutput};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%08h", tag, observed);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs checked #1 later, well away from either edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic t, input logic v, input logic s, input logic [PC_WIDTH-1:0] tgt);
    taken  = t;
    valid  = v;
    stall  = s;
    target = tgt;
    #1;
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);

    // Reset: outputs forced to zero, including write enables.
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_reset_outs", 32'(outs_a), 32'(OUT_ZERO));
    check("a_reset_target", if_a.pcTargetOutput, 32'h0);
    cycle();

    // First cycle after reset is a normal RUN cycle.
    reset_a = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    check("a_first_run", 32'(outs_a), 32'(OUT_RUN));

    // Basic taken branch, FLUSH_CYCLES=2.
    cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0040_0020);
    check("a_T_run", 32'(outs_a), 32'(OUT_RUN));
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_T1_redirect", 32'(outs_a), 32'(OUT_REDIR));
    check("a_T1_target", if_a.pcTargetOutput, 32'h0040_0020);
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_T2_flush", 32'(outs_a), 32'(OUT_FLUSH));
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_T3_run", 32'(outs_a), 32'(OUT_RUN));
    check("a_T3_target_hold", if_a.pcTargetOutput, 32'h0040_0020);

    // Taken branch without a valid EX instruction is ignored.
    cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0000_1234);
    check("a_invalid_branch", 32'(outs_a), 32'(OUT_RUN));
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_invalid_next", 32'(outs_a), 32'(OUT_RUN));
    check("a_invalid_target", if_a.pcTargetOutput, 32'h0040_0020);

    // Load-use stall for three RUN cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(); drive(1'b0, 1'b0, 1'b1, '0);
      check($sformatf("a_stall_%0d", i), 32'(outs_a), 32'(OUT_STALL));
    end

    // Stall and branch together: stall outputs now, redirect next cycle;
    // stall and branch requests during REDIRECT/FLUSH are ignored.
    cycle(); drive(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    check("a_stall_branch", 32'(outs_a), 32'(OUT_STALL));
    cycle(); drive(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("a_sb_redirect", 32'(outs_a), 32'(OUT_REDIR));
    check("a_sb_target", if_a.pcTargetOutput, 32'h0000_0100);
    cycle(); drive(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    check("a_sb_flush_stall", 32'(outs_a), 32'(OUT_FLUSH));
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_sb_run", 32'(outs_a), 32'(OUT_RUN));
    check("a_sb_target_hold", if_a.pcTargetOutput, 32'h0000_0100);

    // Back-to-back: next branch accepted in the first RUN cycle.
    cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_0300);
    check("a_bb1_run", 32'(outs_a), 32'(OUT_RUN));
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_bb1_redirect", 32'(outs_a), 32'(OUT_REDIR));
    check("a_bb1_target", if_a.pcTargetOutput, 32'h0000_0300);
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_bb1_flush", 32'(outs_a), 32'(OUT_FLUSH));
    cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_0400);
    check("a_bb2_run", 32'(outs_a), 32'(OUT_RUN));
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_bb2_redirect", 32'(outs_a), 32'(OUT_REDIR));
    check("a_bb2_target", if_a.pcTargetOutput, 32'h0000_0400);
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_bb2_flush", 32'(outs_a), 32'(OUT_FLUSH));
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("a_bb2_run_after", 32'(outs_a), 32'(OUT_RUN));

`ifdef BRANCH_FLUSH_STATS_EN
    // Four accepted branches, two busy cycles each.
    check("a_branch_count", branch_count_a, 32'd4);
    check("a_flush_cycle_count", flush_cycle_count_a, 32'd8);
`endif

    // Reset during REDIRECT aborts the sequence and clears the target.
    cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_0500);
    check("a_rst_branch", 32'(outs_a), 32'(OUT_RUN));
    cycle(); reset_a = 1'b1; drive(1'b0, 1'b0, 1'b0, '0);
    check("a_rst_mid_outs", 32'(outs_a), 32'(OUT_ZERO));
    cycle(); reset_a = 1'b0; drive(1'b0, 1'b0, 1'b0, '0);
    check("a_rst_after_run", 32'(outs_a), 32'(OUT_RUN));
    check("a_rst_after_target", if_a.pcTargetOutput, 32'h0);
`ifdef BRANCH_FLUSH_STATS_EN
    check("a_rst_branch_count", branch_count_a, 32'd0);
    check("a_rst_flush_count", flush_cycle_count_a, 32'd0);
`endif

    // FLUSH_CYCLES=4 instance; instance a parked in reset.
    cycle(); reset_a = 1'b1; reset_b = 1'b0; drive(1'b0, 1'b0, 1'b0, '0);
    check("b_first_run", 32'(outs_b), 32'(OUT_RUN));
    cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_AAA0);
    check("b_T_run", 32'(outs_b), 32'(OUT_RUN));
    cycle(); reset_b = 1'b1; drive(1'b0, 1'b0, 1'b0, '0);
    check("b_T1_reset_outs", 32'(outs_b), 32'(OUT_ZERO));
    cycle(); reset_b = 1'b0; drive(1'b0, 1'b0, 1'b0, '0);
    check("b_T2_run", 32'(outs_b), 32'(OUT_RUN));
    check("b_T2_target", if_b.pcTargetOutput, 32'h0);
    cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_BBB0);
    check("b_T3_run", 32'(outs_b), 32'(OUT_RUN));
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("b_T4_redirect", 32'(outs_b), 32'(OUT_REDIR));
    check("b_T4_target", if_b.pcTargetOutput, 32'h0000_BBB0);
    for (int i = 0; i < 3; i++) begin
      cycle(); drive(1'b0, 1'b0, 1'b0, '0);
      check($sformatf("b_flush_%0d", i), 32'(outs_b), 32'(OUT_FLUSH));
    end
    cycle(); drive(1'b0, 1'b0, 1'b0, '0);
    check("b_run_after", 32'(outs_b), 32'(OUT_RUN));
`ifdef BRANCH_FLUSH_STATS_EN
    check("b_branch_count", branch_count_b, 32'd1);
    check("b_flush_cycle_count", flush_cycle_count_b, 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
